pcap_stream_widener: RTL and testbench

//  Byte-to-word packetiser behind the pcap replay parser. Packs the parser's byte stream
//  (datavalid/data/pktcount/pcapfinished) into DATA_BYTES-wide words with SOP/EOP/keep framing.

---
 rtl/pcap_stream_widener.sv | 230 +++++++++++++++++++++++
 tb/tb_pcap_stream_widener.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pcap_stream_widener.sv
// pcap_stream_widener: packs the pcap parser byte stream into DATA_BYTES-wide words
// with sop/eop/keep framing, buffers them in a show-ahead FIFO and pauses the parser
// when the FIFO runs low on space.
// Optional statistics outputs (stat_pkts, stat_lastlen) are built when the macro
// PCAP_WIDENER_STATS_EN is defined.
module pcap_stream_widener #(
    parameter int DATA_BYTES  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int PAUSE_SLACK = 2
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic [7:0]              in_pktcount,
    input  logic                    in_finished,
    output logic                    in_pause,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic [DATA_BYTES-1:0]   out_keep,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    overflow,
    output logic                    flush_done
`ifdef PCAP_WIDENER_STATS_EN
    ,
    output logic [15:0]             stat_pkts,
    output logic [15:0]             stat_lastlen
`endif
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(DATA_BYTES + 1);
    localparam int EW = DW + DATA_BYTES + 2;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

    // Byte mask with the lowest n lanes set.
    function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [NW-1:0] n);
        logic [DATA_BYTES-1:0] m;
        m = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (k < int'(n)) m[k] = 1'b1;
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic                acc_sop_q, acc_sop_d;
    logic [7:0]          last_pkt_q, last_pkt_d;
    logic                overflow_q, overflow_d;
    logic                in_pause_q, in_pause_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];

    logic                acc_byte, boundary, full, pop, room;
    logic                wr_req, wr_en, wr_eop;
    logic [DATA_BYTES-1:0] wr_keep;
    logic [EW-1:0]       wr_entry, head;

    assign acc_byte = in_valid & ~in_finished & ((state_q == IDLE) | (state_q == ACC));
    assign boundary = (in_pktcount != last_pkt_q) | (state_q == IDLE);
    assign out_valid = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = out_valid & out_ready;
    assign room     = ~full | pop;
    assign wr_entry = {acc_sop_q, wr_eop, wr_keep, acc_q};
    assign head     = mem_q[rd_ptr_q];

    // Framing FSM and accumulator: decides which word, if any, is written this cycle.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_sop_d  = acc_sop_q;
        last_pkt_d = last_pkt_q;
        overflow_d = overflow_q;
        wr_req     = 1'b0;
        wr_en      = 1'b0;
        wr_eop     = 1'b0;
        wr_keep    = '0;
        case (state_q)
            IDLE, ACC: begin
                if (in_finished) begin
                    state_d = (state_q == IDLE) ? DONE : FLUSH;
                end else if (acc_byte) begin
                    state_d    = ACC;
                    last_pkt_d = in_pktcount;
                    if (boundary && cnt_q != '0) begin
                        wr_req    = 1'b1;
                        wr_keep   = keep_mask(cnt_q);
                        wr_eop    = 1'b1;
                        acc_d     = '0;
                        acc_d[7:0] = in_data;
                        cnt_d     = NW'(1);
                        acc_sop_d = 1'b1;
                    end else if (!boundary && cnt_q == NW'(DATA_BYTES)) begin
                        wr_req    = 1'b1;
                        wr_keep   = '1;
                        acc_d     = '0;
                        acc_d[7:0] = in_data;
                        cnt_d     = NW'(1);
                        acc_sop_d = 1'b0;
                    end else begin
                        for (int k = 0; k < DATA_BYTES; k++) begin
                            if (k == int'(cnt_q)) acc_d[8*k +: 8] = in_data;
                        end
                        cnt_d = cnt_q + NW'(1);
                        if (boundary) acc_sop_d = 1'b1;
                    end
                    // A refused write while accumulating loses the word.
                    wr_en = wr_req & room;
                    if (wr_req && !room) overflow_d = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q != '0) begin
                    wr_req  = 1'b1;
                    wr_keep = keep_mask(cnt_q);
                    wr_eop  = 1'b1;
                    if (room) begin
                        wr_en   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
    end

    // FIFO pointer/occupancy bookkeeping and the pause threshold.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_pause_d = ((FIFO_DEPTH - int'(count_d)) <= PAUSE_SLACK);
    end

    // Control and accumulator state.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            acc_sop_q  <= 1'b0;
            last_pkt_q <= '0;
            overflow_q <= 1'b0;
            in_pause_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            acc_sop_q  <= acc_sop_d;
            last_pkt_q <= last_pkt_d;
            overflow_q <= overflow_d;
            in_pause_q <= in_pause_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge CLOCK) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign out_data   = out_valid ? head[DW-1:0] : '0;
    assign out_keep   = out_valid ? head[DW +: DATA_BYTES] : '0;
    assign out_eop    = out_valid & head[DW+DATA_BYTES];
    assign out_sop    = out_valid & head[DW+DATA_BYTES+1];
    assign overflow   = overflow_q;
    assign in_pause   = in_pause_q;
    assign flush_done = (state_q == DONE);

`ifdef PCAP_WIDENER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] pkt_len_q, pkt_len_d;
    logic [15:0] stat_pkts_q, stat_pkts_d;
    logic [15:0] stat_lastlen_q, stat_lastlen_d;

    // Packet length tracking and per-EOP statistics.
    always_comb begin
        pkt_len_d      = pkt_len_q;
        stat_pkts_d    = stat_pkts_q;
        stat_lastlen_d = stat_lastlen_q;
        if (acc_byte) pkt_len_d = boundary ? 16'd1 : sat_inc16(pkt_len_q);
        if (wr_en && wr_eop) begin
            stat_pkts_d    = sat_inc16(stat_pkts_q);
            stat_lastlen_d = pkt_len_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pkt_len_q      <= '0;
            stat_pkts_q    <= '0;
            stat_lastlen_q <= '0;
        end else begin
            pkt_len_q      <= pkt_len_d;
            stat_pkts_q    <= stat_pkts_d;
            stat_lastlen_q <= stat_lastlen_d;
        end
    end

    assign stat_pkts    = stat_pkts_q;
    assign stat_lastlen = stat_lastlen_q;
`endif

endmodule

// File: tb/tb_pcap_stream_widener.sv
// Directed bench for pcap_stream_widener (DATA_BYTES=4, FIFO_DEPTH=4, PAUSE_SLACK=2).
module tb_pcap_stream_widener;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [7:0]  in_pktcount = '0;
    logic        in_finished = 1'b0;
    logic        in_pause;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_sop, out_eop, overflow, flush_done;
`ifdef PCAP_WIDENER_STATS_EN
    logic [15:0] stat_pkts, stat_lastlen;
`endif

    int n_tests = 0;
    int n_failed = 0;

    logic [31:0] q_data [$];
    logic [3:0]  q_keep [$];
    logic        q_sop  [$];
    logic        q_eop  [$];

    pcap_stream_widener #(.DATA_BYTES(4), .FIFO_DEPTH(4), .PAUSE_SLACK(2)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .in_valid(in_valid), .in_data(in_data), .in_pktcount(in_pktcount),
        .in_finished(in_finished), .in_pause(in_pause),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_sop(out_sop), .out_eop(out_eop),
        .overflow(overflow), .flush_done(flush_done)
`ifdef PCAP_WIDENER_STATS_EN
        , .stat_pkts(stat_pkts), .stat_lastlen(stat_lastlen)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    // Record every word accepted downstream, sampled mid-cycle.
    always @(negedge CLOCK) begin
        if (RESET_N && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_keep.push_back(out_keep);
            q_sop.push_back(out_sop);
            q_eop.push_back(out_eop);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input int idx, input logic [31:0] dmask, input logic [31:0] d,
                              input logic [3:0] k, input logic s, input logic e);
        if (idx >= q_data.size()) begin
            check($sformatf("word%0d_present", idx), 64'(q_data.size()), 64'(idx + 1));
        end else begin
            check($sformatf("word%0d_data", idx), 64'(q_data[idx] & dmask), 64'(d & dmask));
            check($sformatf("word%0d_framing", idx), {57'd0, q_keep[idx], q_sop[idx], q_eop[idx]},
                  {57'd0, k, s, e});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] p);
        in_valid = 1'b1;
        in_data = b;
        in_pktcount = p;
        @(posedge CLOCK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        in_valid = 1'b0;
        in_finished = 1'b0;
        cycles(2);
        RESET_N = 1'b1;
        q_data.delete(); q_keep.delete(); q_sop.delete(); q_eop.delete();
    endtask

    task automatic wait_flush_done(input string tag);
        int n;
        n = 0;
        while (!flush_done && n < 10) begin
            cycles(1);
            n++;
        end
        check(tag, 64'(flush_done), 64'd1);
    endtask

    initial begin
        do_reset();
        check("reset_outputs", {in_pause, out_valid, out_data, out_keep, out_sop, out_eop,
                                overflow, flush_done}, 64'd0);

        // Scenario 1: 6-byte packet closed by a new pktcount.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(i), 8'd1);
        send(8'h10, 8'd2);
        cycles(4);
        check("s1_words", 64'(q_data.size()), 64'd2);
        check_word(0, 32'hFFFFFFFF, 32'h03020100, 4'hF, 1'b1, 1'b0);
        check_word(1, 32'h0000FFFF, 32'h00000504, 4'h3, 1'b0, 1'b1);
`ifdef PCAP_WIDENER_STATS_EN
        check("s1_stat_pkts", 64'(stat_pkts), 64'd1);
        check("s1_stat_lastlen", 64'(stat_lastlen), 64'd6);
`endif

        // Scenario 2: 8 bytes then finish flushes the held full word.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 8'd1);
        check("s2_not_done_yet", 64'(flush_done), 64'd0);
        in_finished = 1'b1;
        wait_flush_done("s2_flush_done");
        send(8'h99, 8'd1);
        cycles(4);
        check("s2_words", 64'(q_data.size()), 64'd2);
        check_word(0, 32'hFFFFFFFF, 32'h23222120, 4'hF, 1'b1, 1'b0);
        check_word(1, 32'hFFFFFFFF, 32'h27262524, 4'hF, 1'b0, 1'b1);
        check("s2_flush_done_held", 64'(flush_done), 64'd1);

        // Scenario 3: two 1-byte packets.
        do_reset();
        out_ready = 1'b1;
        send(8'hAA, 8'd3);
        send(8'hBB, 8'd4);
        in_finished = 1'b1;
        wait_flush_done("s3_flush_done");
        cycles(3);
        check("s3_words", 64'(q_data.size()), 64'd2);
        check_word(0, 32'h000000FF, 32'h000000AA, 4'h1, 1'b1, 1'b1);
        check_word(1, 32'h000000FF, 32'h000000BB, 4'h1, 1'b1, 1'b1);

        // Scenario 4: stalled output raises pause at two free slots.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i), 8'd1);
        check("s4_pause_one_word", 64'(in_pause), 64'd0);
        send(8'd8, 8'd1);
        check("s4_pause_two_words", 64'(in_pause), 64'd1);
        check("s4_no_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        cycles(6);
        check("s4_words", 64'(q_data.size()), 64'd2);
        check_word(0, 32'hFFFFFFFF, 32'h03020100, 4'hF, 1'b1, 1'b0);
        check_word(1, 32'hFFFFFFFF, 32'h07060504, 4'hF, 1'b0, 1'b0);
        check("s4_pause_released", 64'(in_pause), 64'd0);

        // Scenario 5: pause ignored, fifth word is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(8'(i), 8'd1);
        check("s5_full_no_overflow", 64'(overflow), 64'd0);
        for (int i = 17; i < 21; i++) send(8'(i), 8'd1);
        check("s5_overflow", 64'(overflow), 64'd1);
        check("s5_head_stable", 64'(out_data), 64'h03020100);
        out_ready = 1'b1;
        cycles(8);
        check("s5_words", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_word(i, 32'hFFFFFFFF, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)},
                       4'hF, (i == 0), 1'b0);
        end
        check("s5_overflow_sticky", 64'(overflow), 64'd1);

        // Scenario 6: asynchronous reset mid-packet.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), 8'd5);
        check("s6_valid_before", 64'(out_valid), 64'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("s6_async_reset_outputs", {in_pause, out_valid, out_data, out_keep, out_sop,
                                         out_eop, overflow, flush_done}, 64'd0);
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        q_data.delete(); q_keep.delete(); q_sop.delete(); q_eop.delete();
        out_ready = 1'b1;
        send(8'h77, 8'd5);
        send(8'h88, 8'd6);
        cycles(4);
        check("s6_words", 64'(q_data.size()), 64'd1);
        check_word(0, 32'h000000FF, 32'h00000077, 4'h1, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
